// File: rtl/present80_inv_keysched.sv
`default_nettype none
// ============================================================================
// Module      : present80_inv_keysched
// Description : PRESENT-80 decryption round-key generator. Expands the master
//               key forward through all 31 schedule updates, then walks the
//               schedule backwards to serve round keys K32..K1 over a
//               valid/ready handshake. Only one 80-bit key state is held.
// Revision    : 1.0 - initial release
// ============================================================================
module present80_inv_keysched (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [79:0] key_in,
    input  logic        rk_ready,
    output logic [63:0] rk_out,
    output logic [5:0]  rk_idx,
    output logic        rk_valid,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_OUT    = 2'd2
    } state_t;

    state_t      state_q;
    logic [79:0] key_q;
    logic [5:0]  cnt_q;
    logic        done_q;

    logic [79:0] key_fwd_d;
    logic [79:0] key_inv_d;
    logic [4:0]  cnt_dec_d;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    // Forward step: rotate left 61, S-box the top nibble, mix in the counter.
    function automatic logic [79:0] fwd_update(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox(r[79:76]);
        r[19:15]   = r[19:15] ^ i;
        return r;
    endfunction

    // Exact inverse of fwd_update, undoing its three steps in reverse order.
    function automatic logic [79:0] inv_update(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] r;
        r          = k;
        r[19:15]   = r[19:15] ^ i;
        r[79:76]   = sbox_inv(r[79:76]);
        r          = {r[60:0], r[79:61]};
        return r;
    endfunction

    // Counter used by the inverse step is cnt-1; at cnt=32 the 5-bit wrap gives 31.
    assign cnt_dec_d = cnt_q[4:0] - 5'd1;
    assign key_fwd_d = fwd_update(key_q, cnt_q[4:0]);
    assign key_inv_d = inv_update(key_q, cnt_dec_d);

    // Control FSM with key register, round counter and registered done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            key_q   <= 80'd0;
            cnt_q   <= 6'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        key_q   <= key_in;
                        cnt_q   <= 6'd1;
                        state_q <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    key_q <= key_fwd_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_q <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (rk_ready) begin
                        if (cnt_q == 6'd1) begin
                            cnt_q   <= 6'd0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            key_q <= key_inv_d;
                            cnt_q <= cnt_q - 6'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from registers only; nothing depends on rk_ready.
    assign rk_out   = key_q[79:16];
    assign rk_valid = (state_q == S_OUT);
    assign rk_idx   = rk_valid ? cnt_q : 6'd0;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_present80_inv_keysched.sv
`default_nettype none
// ============================================================================
// Module      : tb_present80_inv_keysched
// Description : Directed and randomized checks of the PRESENT-80 inverse key
//               schedule generator against a forward software key schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_present80_inv_keysched;

    logic        clk;
    logic        rst;
    logic        start;
    logic [79:0] key_in;
    logic        rk_ready;
    logic [63:0] rk_out;
    logic [5:0]  rk_idx;
    logic        rk_valid;
    logic        busy;
    logic        done;

    int          n_checks;
    int          n_errors;
    logic [63:0] exp_rk [1:32];
    logic [63:0] got_rk [1:32];
    logic [63:0] sbox_tab;

    present80_inv_keysched dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Standard forward PRESENT-80 schedule: round key r is key_reg[79:16] before update r.
    task automatic build_model(input logic [79:0] key);
        logic [79:0] k;
        logic [4:0]  c;
        k = key;
        exp_rk[1] = k[79:16];
        for (int i = 1; i <= 31; i++) begin
            c        = i[4:0];
            k        = {k[18:0], k[79:19]};
            k[79:76] = sbox_tab[63 - 4 * int'(k[79:76]) -: 4];
            k[19:15] = k[19:15] ^ c;
            exp_rk[i + 1] = k[79:16];
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 80'(rk_valid), 80'(0));
        check({tag, "_idx"},   80'(rk_idx),   80'(0));
        check({tag, "_busy"},  80'(busy),     80'(0));
        check({tag, "_done"},  80'(done),     80'(0));
        check({tag, "_rkout"}, 80'(rk_out),   80'(0));
    endtask

    // Asynchronous reset mid-job: outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort_rst");
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", 80'(done), 80'(0));
            check("abort_idle",    80'(busy), 80'(0));
        end
    endtask

    // One job: start at the next edge, expand, then collect 32 keys.
    task automatic run_job(input logic [79:0] key, input bit stall, input bit inject,
                           input int abort_lat, input int abort_idx);
        int lat;
        int exp_idx;
        int xfers;
        int guard;
        bit rdy;
        build_model(key);
        key_in = key;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 80'(busy), 80'(1));
        lat = 0;
        while (!rk_valid && lat < 100) begin
            if (abort_lat != 0 && lat == abort_lat) begin
                do_reset();
                return;
            end
            start  = inject && (lat == 10);
            key_in = (inject && lat == 10) ? ~key : key;
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check("first_key_latency", 80'(lat), 80'(31));
        exp_idx = 32;
        xfers   = 0;
        guard   = 0;
        while (xfers < 32 && guard < 2000) begin
            if (abort_idx != 0 && exp_idx == abort_idx) begin
                do_reset();
                return;
            end
            check("rk_valid", 80'(rk_valid), 80'(1));
            check("rk_idx",   80'(rk_idx),   80'(exp_idx));
            check("rk_out",   80'(rk_out),   80'(exp_rk[exp_idx]));
            check("done_low", 80'(done),     80'(0));
            got_rk[exp_idx] = rk_out;
            rdy      = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            rk_ready = rdy;
            start    = inject && (xfers == 5);
            key_in   = (inject && xfers == 5) ? ~key : key;
            @(posedge clk);
            #1;
            guard++;
            if (rdy) begin
                exp_idx--;
                xfers++;
            end
        end
        start    = 1'b0;
        rk_ready = 1'b1;
        check("xfer_count",    80'(xfers),    80'(32));
        check("done_pulse",    80'(done),     80'(1));
        check("busy_fall",     80'(busy),     80'(0));
        check("valid_fall",    80'(rk_valid), 80'(0));
        check("idx_after_end", 80'(rk_idx),   80'(0));
    endtask

    initial begin
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] r2;
        n_checks = 0;
        n_errors = 0;
        sbox_tab = 64'hC56B90AD3EF84712;
        rst      = 1'b0;
        start    = 1'b0;
        key_in   = 80'd0;
        rk_ready = 1'b1;
        #1;
        rst = 1'b1;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_reset", 80'(busy), 80'(0));

        // All-zero key, ready tied high.
        run_job(80'd0, 1'b0, 1'b0, 0, 0);
        check("k0_K2", 80'(got_rk[2]), 80'(64'hC000000000000000));
        check("k0_K1", 80'(got_rk[1]), 80'(64'h0000000000000000));
        @(posedge clk);
        #1;
        check("done_single_cycle", 80'(done), 80'(0));

        // All-ones key, ready tied high.
        run_job({80{1'b1}}, 1'b0, 1'b0, 0, 0);
        check("kF_K2", 80'(got_rk[2]), 80'(64'h2FFFFFFFFFFFFFFF));
        check("kF_K1", 80'(got_rk[1]), 80'(64'hFFFFFFFFFFFFFFFF));
        @(posedge clk);
        #1;

        // Spurious start during EXPAND and OUT must be ignored.
        run_job(80'h0123456789ABCDEF0123, 1'b0, 1'b1, 0, 0);
        @(posedge clk);
        #1;

        // Reset mid-EXPAND, then a clean job.
        run_job(80'hDEADBEEFCAFEF00D1234, 1'b1, 1'b0, 15, 0);
        run_job(80'hDEADBEEFCAFEF00D1234, 1'b0, 1'b0, 0, 0);
        @(posedge clk);
        #1;

        // Reset mid-OUT after K20 accepted, then a clean stalled job.
        run_job(80'h13579BDF02468ACE1111, 1'b0, 1'b0, 0, 19);
        run_job(80'h13579BDF02468ACE1111, 1'b1, 1'b0, 0, 0);

        // Back-to-back: start issued in the done cycle's following edge.
        run_job(80'hA5A5A5A5A5A5A5A5A5A5, 1'b0, 1'b0, 0, 0);
        run_job(80'h5A5A5A5A5A5A5A5A5A5A, 1'b0, 1'b0, 0, 0);

        // Random keys with random stalls, also back-to-back.
        for (int j = 0; j < 100; j++) begin
            r0 = $urandom;
            r1 = $urandom;
            r2 = $urandom;
            run_job({r0, r1, r2[15:0]}, 1'b1, 1'b0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
